// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: size codes,
// FSM/owner encodings and the access-length helper.
package mem_ctrl_pkg;

    localparam logic RST_ENABLE = 1'b1;
    localparam logic TRUE_V     = 1'b1;

    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    // Number of bytes moved for a size code; code 3 behaves as a word.
    function automatic logic [2:0] size_to_len(input logic [1:0] size);
        logic [2:0] len;
        case (size)
            MEM_BYTE: len = 3'd1;
            MEM_HALF: len = 3'd2;
            default:  len = 3'd4;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/mem_ctrl_ext.sv
// Size mask plus sign/zero extension of a little-endian assembled 32-bit value.
// Kept standalone so MEM-stage forwarding checks can reuse it.
module mem_ctrl_ext
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  size,
    input  logic        sign_en,
    output logic [31:0] result
);

    logic fill_byte_s;
    logic fill_half_s;

    assign fill_byte_s = sign_en & raw[7];
    assign fill_half_s = sign_en & raw[15];

    // Select extension width from the access size.
    always_comb begin
        result = raw;
        case (size)
            MEM_BYTE: result = {{24{fill_byte_s}}, raw[7:0]};
            MEM_HALF: result = {{16{fill_half_s}}, raw[15:0]};
            default:  result = raw;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Shares one byte-wide RAM port between instruction fetch and the MEM stage,
// serialising 8/16/32-bit little-endian loads and stores.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_re,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_done,
    input  logic              mem_re,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [1:0]        mem_size,
    input  logic              mem_signed,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_a,
    output logic [7:0]        ram_dout,
    output logic              ram_wr,
    input  logic [7:0]        ram_din
);

    localparam logic [2:0] LAT_C = 3'(RAM_LAT);

    state_t            state_r,     state_s;
    owner_t            owner_r,     owner_s;
    logic [2:0]        cnt_r,       cnt_s;
    logic [ADDR_W-1:0] addr_r,      addr_s;
    logic [1:0]        size_r,      size_s;
    logic [31:0]       wdata_r,     wdata_s;
    logic              signed_r,    signed_s;
    logic [31:0]       buf_r,       buf_s;
    logic [ADDR_W-1:0] ram_a_r,     ram_a_s;
    logic [7:0]        ram_dout_r,  ram_dout_s;
    logic              ram_wr_r,    ram_wr_s;
    logic              if_done_r,   if_done_s;
    logic              mem_done_r,  mem_done_s;
    logic [31:0]       if_rdata_r,  if_rdata_s;
    logic [31:0]       mem_rdata_r, mem_rdata_s;
    logic              busy_r,      busy_s;

    logic [2:0]        len_s;
    logic [2:0]        rd_last_s;
    logic [1:0]        rd_idx_s;
    logic [1:0]        wr_idx_s;
    logic [31:0]       ext_s;

    assign len_s     = size_to_len(size_r);
    // The final read count covers the RAM latency drain after the last address.
    assign rd_last_s = len_s + LAT_C - 3'd1;
    assign rd_idx_s  = 2'(cnt_r - LAT_C);
    assign wr_idx_s  = cnt_r[1:0] + 2'd1;

    mem_ctrl_ext u_ext (
        .raw     (buf_s),
        .size    (size_r),
        .sign_en (signed_r),
        .result  (ext_s)
    );

    // Assemble returned RAM bytes; cleared while idle so short loads start clean.
    always_comb begin
        buf_s = buf_r;
        if (rdy == TRUE_V) begin
            if (state_r == ST_IDLE) begin
                buf_s = 32'h0000_0000;
            end else if ((state_r == ST_RD) && (cnt_r >= LAT_C)) begin
                buf_s[{rd_idx_s, 3'b000} +: 8] = ram_din;
            end else begin
                buf_s = buf_r;
            end
        end else begin
            buf_s = buf_r;
        end
    end

    // Next-state, arbitration and next values of all registered outputs.
    always_comb begin
        state_s     = state_r;
        owner_s     = owner_r;
        cnt_s       = cnt_r;
        addr_s      = addr_r;
        size_s      = size_r;
        wdata_s     = wdata_r;
        signed_s    = signed_r;
        ram_a_s     = ram_a_r;
        ram_dout_s  = ram_dout_r;
        ram_wr_s    = ram_wr_r;
        if_done_s   = if_done_r;
        mem_done_s  = mem_done_r;
        if_rdata_s  = if_rdata_r;
        mem_rdata_s = mem_rdata_r;
        if (rdy == TRUE_V) begin
            if_done_s  = 1'b0;
            mem_done_s = 1'b0;
            case (state_r)
                ST_IDLE: begin
                    cnt_s = 3'd0;
                    if (mem_we) begin
                        state_s    = ST_WR;
                        owner_s    = OWN_MEM;
                        addr_s     = mem_addr;
                        size_s     = mem_size;
                        wdata_s    = mem_wdata;
                        signed_s   = 1'b0;
                        ram_a_s    = mem_addr;
                        ram_dout_s = mem_wdata[7:0];
                        ram_wr_s   = 1'b1;
                    end else if (mem_re) begin
                        state_s  = ST_RD;
                        owner_s  = OWN_MEM;
                        addr_s   = mem_addr;
                        size_s   = mem_size;
                        signed_s = mem_signed;
                        ram_a_s  = mem_addr;
                    end else if (if_re) begin
                        state_s  = ST_RD;
                        owner_s  = OWN_IF;
                        addr_s   = if_addr;
                        size_s   = MEM_WORD;
                        signed_s = 1'b0;
                        ram_a_s  = if_addr;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_RD: begin
                    if (cnt_r == rd_last_s) begin
                        state_s = ST_DONE;
                        if (owner_r == OWN_IF) begin
                            if_done_s  = 1'b1;
                            if_rdata_s = ext_s;
                        end else begin
                            mem_done_s  = 1'b1;
                            mem_rdata_s = ext_s;
                        end
                    end else if (cnt_r < (len_s - 3'd1)) begin
                        cnt_s   = cnt_r + 3'd1;
                        ram_a_s = addr_r + ADDR_W'(cnt_r + 3'd1);
                    end else begin
                        cnt_s = cnt_r + 3'd1;
                    end
                end
                ST_WR: begin
                    if (cnt_r == (len_s - 3'd1)) begin
                        state_s    = ST_DONE;
                        ram_wr_s   = 1'b0;
                        mem_done_s = 1'b1;
                    end else begin
                        cnt_s      = cnt_r + 3'd1;
                        ram_a_s    = addr_r + ADDR_W'(cnt_r + 3'd1);
                        ram_dout_s = wdata_r[{wr_idx_s, 3'b000} +: 8];
                    end
                end
                ST_DONE: begin
                    state_s = ST_IDLE;
                    cnt_s   = 3'd0;
                end
                default: begin
                    state_s  = ST_IDLE;
                    cnt_s    = 3'd0;
                    ram_wr_s = 1'b0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    assign busy_s = (state_s != ST_IDLE);

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state_r     <= ST_IDLE;
            owner_r     <= OWN_IF;
            cnt_r       <= 3'd0;
            addr_r      <= {ADDR_W{1'b0}};
            size_r      <= MEM_WORD;
            wdata_r     <= 32'h0000_0000;
            signed_r    <= 1'b0;
            buf_r       <= 32'h0000_0000;
            ram_a_r     <= {ADDR_W{1'b0}};
            ram_dout_r  <= 8'h00;
            ram_wr_r    <= 1'b0;
            if_done_r   <= 1'b0;
            mem_done_r  <= 1'b0;
            if_rdata_r  <= 32'h0000_0000;
            mem_rdata_r <= 32'h0000_0000;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            owner_r     <= owner_s;
            cnt_r       <= cnt_s;
            addr_r      <= addr_s;
            size_r      <= size_s;
            wdata_r     <= wdata_s;
            signed_r    <= signed_s;
            buf_r       <= buf_s;
            ram_a_r     <= ram_a_s;
            ram_dout_r  <= ram_dout_s;
            ram_wr_r    <= ram_wr_s;
            if_done_r   <= if_done_s;
            mem_done_r  <= mem_done_s;
            if_rdata_r  <= if_rdata_s;
            mem_rdata_r <= mem_rdata_s;
            busy_r      <= busy_s;
        end
    end

    assign if_rdata  = if_rdata_r;
    assign if_done   = if_done_r;
    assign mem_rdata = mem_rdata_r;
    assign mem_done  = mem_done_r;
    assign busy      = busy_r;
    assign ram_a     = ram_a_r;
    assign ram_dout  = ram_dout_r;
    // A stalled pipeline must never see a write strobe.
    assign ram_wr    = ram_wr_r & rdy;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: a byte-array RAM with one-cycle read
// latency, a write log, and a reference built from byte/size/sign rules.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        if_re, if_done, mem_re, mem_we, mem_signed, mem_done, busy, ram_wr;
    logic [31:0] if_addr, if_rdata, mem_addr, mem_wdata, mem_rdata, ram_a;
    logic [1:0]  mem_size;
    logic [7:0]  ram_dout, ram_din;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ram_arr [0:1023];
    logic [39:0] wlog [$];
    logic [31:0] tr_a [0:15];
    logic        tr_busy [0:15];

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_re(if_re), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_size(mem_size), .mem_signed(mem_signed), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .busy(busy), .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din)
    );

    always #5 clk = ~clk;

    // RAM: one-cycle read latency, output held while the pipeline is stalled.
    always @(posedge clk) if (rdy) ram_din <= ram_arr[ram_a[9:0]];

    always @(negedge clk) if (ram_wr === 1'b1) wlog.push_back({ram_a, ram_dout});

    function automatic int exp_len(input int sz);
        if (sz == 0) return 1;
        else if (sz == 1) return 2;
        else return 4;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] a, input int sz, input bit sgn);
        longint v = 0;
        int n = exp_len(sz);
        logic [31:0] ai;
        for (int i = 0; i < n; i++) begin
            ai = a + 32'(i);
            v = v + (longint'(ram_arr[ai[9:0]]) << (8 * i));
        end
        if (sgn && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    // Issue one request (0 fetch, 1 load, 2 store), hold it until done or the budget expires.
    task automatic run_req(input int kind, input logic [31:0] a, input int sz, input bit sg,
                           input logic [31:0] wd, output int lat_o, output logic [31:0] data_o);
        @(posedge clk); #1;
        if (kind == 0) begin if_re = 1'b1; if_addr = a; end
        else if (kind == 1) begin mem_re = 1'b1; mem_addr = a; mem_size = 2'(sz); mem_signed = sg; end
        else begin mem_we = 1'b1; mem_addr = a; mem_size = 2'(sz); mem_wdata = wd; end
        lat_o = -1;
        data_o = 32'h0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            tr_a[k] = ram_a;
            tr_busy[k] = busy;
            if ((kind == 0 && if_done === 1'b1) || (kind != 0 && mem_done === 1'b1)) begin
                lat_o = k;
                data_o = (kind == 0) ? if_rdata : mem_rdata;
                break;
            end
        end
        if_re = 1'b0; mem_re = 1'b0; mem_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (if_done !== 1'b0) begin errors++; $display("FAIL reset_if_done got=%b exp=0", if_done); end
        checks++; if (mem_done !== 1'b0) begin errors++; $display("FAIL reset_mem_done got=%b exp=0", mem_done); end
        checks++; if (if_rdata !== 32'h0) begin errors++; $display("FAIL reset_if_rdata got=%h exp=0", if_rdata); end
        checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_mem_rdata got=%h exp=0", mem_rdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (ram_a !== 32'h0) begin errors++; $display("FAIL reset_ram_a got=%h exp=0", ram_a); end
        checks++; if (ram_dout !== 8'h0) begin errors++; $display("FAIL reset_ram_dout got=%h exp=0", ram_dout); end
        checks++; if (ram_wr !== 1'b0) begin errors++; $display("FAIL reset_ram_wr got=%b exp=0", ram_wr); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        int lat; logic [31:0] got; bit ok;
        ram_arr[10'h100] = 8'h13; ram_arr[10'h101] = 8'h00;
        ram_arr[10'h102] = 8'h00; ram_arr[10'h103] = 8'h00;
        run_req(0, 32'h100, 2, 1'b0, 32'h0, lat, got);
        checks++; if (lat != 6) begin errors++; $display("FAIL fetch_latency got=%0d exp=6", lat); end
        checks++; if (got !== 32'h0000_0013) begin errors++; $display("FAIL fetch_data got=%h exp=00000013", got); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tr_a[i+1] !== 32'h100 + 32'(i)) begin
                errors++; $display("FAIL fetch_addr cycle=%0d got=%h exp=%h", i + 1, tr_a[i+1], 32'h100 + 32'(i));
            end
        end
        ok = (tr_busy[0] === 1'b0);
        for (int k = 1; k <= 6; k++) ok = ok && (tr_busy[k] === 1'b1);
        checks++; if (!ok) begin errors++; $display("FAIL fetch_busy_window got=wrong exp=low_c0_high_c1_to_c6"); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fetch_busy_after got=%b exp=0", busy); end
        checks++; if (if_rdata !== 32'h13) begin errors++; $display("FAIL fetch_hold got=%h exp=00000013", if_rdata); end
    endtask

    task automatic test_signed_byte();
        int lat; logic [31:0] got;
        ram_arr[10'h001] = 8'h80;
        run_req(1, 32'h2001, 0, 1'b1, 32'h0, lat, got);
        checks++; if (lat != 3) begin errors++; $display("FAIL sbyte_latency got=%0d exp=3", lat); end
        checks++; if (got !== 32'hFFFF_FF80) begin errors++; $display("FAIL sbyte_signed got=%h exp=ffffff80", got); end
        run_req(1, 32'h2001, 0, 1'b0, 32'h0, lat, got);
        checks++; if (got !== 32'h0000_0080) begin errors++; $display("FAIL sbyte_unsigned got=%h exp=00000080", got); end
    endtask

    task automatic test_store();
        int lat; logic [31:0] got; logic [39:0] e, x;
        logic [7:0] bytes_exp [0:3];
        bytes_exp[0] = 8'hEF; bytes_exp[1] = 8'hBE; bytes_exp[2] = 8'hAD; bytes_exp[3] = 8'hDE;
        wlog.delete();
        run_req(2, 32'h3FFE, 2, 1'b0, 32'hDEAD_BEEF, lat, got);
        checks++; if (lat != 5) begin errors++; $display("FAIL store_latency got=%0d exp=5", lat); end
        checks++; if (wlog.size() != 4) begin errors++; $display("FAIL store_wr_cycles got=%0d exp=4", wlog.size()); end
        for (int i = 0; i < 4; i++) begin
            x = {32'h3FFE + 32'(i), bytes_exp[i]};
            e = (i < wlog.size()) ? wlog[i] : 40'h0;
            checks++; if (e !== x) begin errors++; $display("FAIL store_byte%0d got=%h exp=%h", i, e, x); end
        end
        checks++; if (mem_rdata !== 32'h80) begin errors++; $display("FAIL store_rdata_hold got=%h exp=00000080", mem_rdata); end
    endtask

    task automatic test_collision();
        int md, id; logic [31:0] mg, ig, ie, me;
        ie = exp_load(32'h200, 2, 1'b0);
        me = exp_load(32'h380, 1, 1'b1);
        @(posedge clk); #1;
        if_re = 1'b1; if_addr = 32'h200;
        mem_re = 1'b1; mem_addr = 32'h380; mem_size = 2'd1; mem_signed = 1'b1;
        md = -1; id = -1; mg = 32'h0; ig = 32'h0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mem_done === 1'b1 && md < 0) begin md = k; mg = mem_rdata; mem_re = 1'b0; end
            if (if_done === 1'b1 && id < 0) begin id = k; ig = if_rdata; if_re = 1'b0; end
            if (md >= 0 && id >= 0) break;
        end
        if_re = 1'b0; mem_re = 1'b0;
        checks++; if (md != 4) begin errors++; $display("FAIL coll_mem_first got=%0d exp=4", md); end
        checks++; if (id != 11) begin errors++; $display("FAIL coll_if_next got=%0d exp=11", id); end
        checks++; if (mg !== me) begin errors++; $display("FAIL coll_mem_data got=%h exp=%h", mg, me); end
        checks++; if (ig !== ie) begin errors++; $display("FAIL coll_if_data got=%h exp=%h", ig, ie); end
    endtask

    task automatic test_wrap();
        int lat; logic [31:0] got, ex;
        ex = exp_load(32'hFFFF_FFFF, 1, 1'b0);
        run_req(1, 32'hFFFF_FFFF, 1, 1'b0, 32'h0, lat, got);
        checks++; if (tr_a[1] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_addr0 got=%h exp=ffffffff", tr_a[1]); end
        checks++; if (tr_a[2] !== 32'h0) begin errors++; $display("FAIL wrap_addr1 got=%h exp=00000000", tr_a[2]); end
        checks++; if (lat != 4) begin errors++; $display("FAIL wrap_latency got=%0d exp=4", lat); end
        checks++; if (got !== ex) begin errors++; $display("FAIL wrap_data got=%h exp=%h", got, ex); end
    endtask

    task automatic test_rdy_pause();
        int lat; logic [31:0] got, ex;
        ex = exp_load(32'h40, 2, 1'b0);
        @(posedge clk); #1;
        mem_re = 1'b1; mem_addr = 32'h40; mem_size = 2'd2; mem_signed = 1'b0;
        lat = -1; got = 32'h0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (mem_done === 1'b1) begin lat = k; got = mem_rdata; break; end
            if (k == 2) rdy = 1'b0;
            if (k == 5) rdy = 1'b1;
        end
        mem_re = 1'b0; rdy = 1'b1;
        checks++; if (lat != 9) begin errors++; $display("FAIL pause_latency got=%0d exp=9", lat); end
        checks++; if (got !== ex) begin errors++; $display("FAIL pause_data got=%h exp=%h", got, ex); end
    endtask

    task automatic test_rst_write();
        bit saw_wr, saw_done;
        wlog.delete();
        @(posedge clk); #1;
        mem_we = 1'b1; mem_addr = 32'h500; mem_wdata = 32'h1234_5678; mem_size = 2'd2;
        repeat (3) @(negedge clk);
        rst = 1'b1; mem_we = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        saw_wr = 1'b0; saw_done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (ram_wr !== 1'b0) saw_wr = 1'b1;
            if (mem_done !== 1'b0) saw_done = 1'b1;
        end
        checks++; if (saw_wr) begin errors++; $display("FAIL rstwr_ram_wr got=1 exp=0"); end
        checks++; if (saw_done) begin errors++; $display("FAIL rstwr_no_done got=1 exp=0"); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstwr_busy got=%b exp=0", busy); end
        checks++; if (wlog.size() != 2) begin errors++; $display("FAIL rstwr_bytes got=%0d exp=2", wlog.size()); end
    endtask

    task automatic test_back_to_back();
        int d1, d2; logic [31:0] g1, g2, e1, e2;
        e1 = exp_load(32'h10, 2, 1'b0);
        e2 = exp_load(32'h20, 2, 1'b0);
        @(posedge clk); #1;
        if_re = 1'b1; if_addr = 32'h10;
        d1 = -1; d2 = -1; g1 = 32'h0; g2 = 32'h0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (if_done === 1'b1) begin
                if (d1 < 0) begin d1 = k; g1 = if_rdata; if_addr = 32'h20; end
                else begin d2 = k; g2 = if_rdata; break; end
            end
        end
        if_re = 1'b0;
        checks++; if (d1 != 6) begin errors++; $display("FAIL b2b_first got=%0d exp=6", d1); end
        checks++; if (d2 != 13) begin errors++; $display("FAIL b2b_second got=%0d exp=13", d2); end
        checks++; if (g1 !== e1) begin errors++; $display("FAIL b2b_data1 got=%h exp=%h", g1, e1); end
        checks++; if (g2 !== e2) begin errors++; $display("FAIL b2b_data2 got=%h exp=%h", g2, e2); end
    endtask

    task automatic test_random();
        int kind, sz, n, lat, exp_lat;
        bit sg, have_if, have_mem;
        logic [31:0] a, wd, got, ex, last_if, last_mem;
        logic [39:0] e, x;
        have_if = 1'b0; have_mem = 1'b0; last_if = 32'h0; last_mem = 32'h0;
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 2);
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            sz = $urandom_range(0, 3);
            sg = 1'($urandom_range(0, 1));
            wd = $urandom;
            if (kind == 0) begin sz = 2; sg = 1'b0; end
            n = exp_len(sz);
            ex = exp_load(a, sz, sg);
            wlog.delete();
            run_req(kind, a, sz, sg, wd, lat, got);
            exp_lat = (kind == 2) ? n + 1 : n + 2;
            checks++; if (lat != exp_lat) begin errors++; $display("FAIL rnd_latency it=%0d kind=%0d got=%0d exp=%0d", it, kind, lat, exp_lat); end
            if (kind == 2) begin
                checks++; if (wlog.size() != n) begin errors++; $display("FAIL rnd_wr_count it=%0d got=%0d exp=%0d", it, wlog.size(), n); end
                for (int i = 0; i < n; i++) begin
                    x = {a + 32'(i), 8'((wd >> (8 * i)) & 32'hFF)};
                    e = (i < wlog.size()) ? wlog[i] : 40'h0;
                    checks++; if (e !== x) begin errors++; $display("FAIL rnd_wr_byte it=%0d i=%0d got=%h exp=%h", it, i, e, x); end
                end
            end else begin
                checks++; if (got !== ex) begin errors++; $display("FAIL rnd_data it=%0d kind=%0d got=%h exp=%h", it, kind, got, ex); end
                checks++; if (tr_a[1] !== a) begin errors++; $display("FAIL rnd_addr it=%0d got=%h exp=%h", it, tr_a[1], a); end
                if (kind == 0) begin last_if = ex; have_if = 1'b1; end
                else begin last_mem = ex; have_mem = 1'b1; end
            end
            if (kind != 0 && have_if) begin
                checks++; if (if_rdata !== last_if) begin errors++; $display("FAIL rnd_if_hold it=%0d got=%h exp=%h", it, if_rdata, last_if); end
            end
            if (kind != 1 && have_mem) begin
                checks++; if (mem_rdata !== last_mem) begin errors++; $display("FAIL rnd_mem_hold it=%0d got=%h exp=%h", it, mem_rdata, last_mem); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram_arr[i] = 8'($urandom);
        rst = 1'b1; rdy = 1'b1;
        if_re = 1'b0; if_addr = 32'h0;
        mem_re = 1'b0; mem_we = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
        mem_size = 2'd0; mem_signed = 1'b0;
        test_reset();
        test_fetch();
        test_signed_byte();
        test_store();
        test_collision();
        test_wrap();
        test_rdy_pause();
        test_back_to_back();
        test_rst_write();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller that shares the single byte-wide RAM port between instruction fetch (IF) and the MEM stage. It serialises 8/16/32-bit loads and stores into little-endian byte transactions. It also reports busy/done back to the pipeline, so the stall controller can hold IF or MEM until the access completes. The block sits between the core (IF, MEM) and the external RAM.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- RAM_LAT, 1, cycles from address on `ram_a` to byte valid on `ram_din`; fixed at 1 in this design

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset; synchronous, active-high; highest priority
- rdy  in  1  global enable; when low, all state frozen and `ram_wr` forced 0
- if_re  in  1  IF fetch request, held high until `if_done`
- if_addr  in  32  fetch address (word)
- if_rdata  out  32  fetched instruction, valid while `if_done`=1
- if_done  out  1  one-cycle pulse, fetch complete
- mem_re  in  1  MEM load request, held until `mem_done`
- mem_we  in  1  MEM store request, held until `mem_done`; never asserted together with `mem_re`
- mem_addr  in  32  load/store byte address
- mem_wdata  in  32  store data, low bytes used per size
- mem_size  in  2  0=byte, 1=half, 2=word; 3 treated as word
- mem_signed  in  1  1 = sign-extend load result
- mem_rdata  out  32  load result, valid while `mem_done`=1
- mem_done  out  1  one-cycle pulse, load or store complete
- busy  out  1  high whenever state ≠ IDLE
- ram_a  out  32  RAM byte address
- ram_dout  out  8  RAM write byte
- ram_wr  out  1  RAM write strobe (1 = write)
- ram_din  in  8  RAM read byte

## Operation
States:
- IDLE: accepts a new request.
- RD: byte reads.
- WR: byte writes.
- DONE: pulses `if_done` or `mem_done` for one cycle, then returns to IDLE.

Arbitration:
- Sampled only in IDLE with `rdy`=1. Priority order: `mem_we` > `mem_re` > `if_re`.
- On accept, latch the owner, address, size (IF always word), wdata and signed flag. Later input changes are ignored until DONE.
- The losing requester stays pending and is served next from IDLE. There is no fairness counter; the MEM stage is older in the pipeline.

Byte counter:
- `cnt` counts up from 0 to n−1, with n = 1/2/4 from size.
- `ram_a` = latched_addr + cnt, modulo 2^32; 0xFFFFFFFF+1 wraps to 0x00000000.

RD:
- Drives address byte cnt each cycle.
- The byte returned one cycle later is written to `buf[8*(cnt−1)+:8]`.
- One extra drain cycle follows the last address.
- Result: zero- or sign-extended from bit 8n−1 when `mem_signed`; IF is never extended.

WR:
- `ram_wr`=1 and `ram_dout` = wdata byte cnt for n cycles, then DONE.

Outputs:
- `if_rdata`/`mem_rdata` hold the last result until the next completion for that owner.
- `ram_wr` is 0 outside WR.

Reset and rdy:
- Reset mid-access: the access is aborted and no done pulse is issued. The requester re-issues, since it still holds its request.
- `rdy` low mid-access: the whole FSM pauses and resumes exactly where it stopped. The RAM byte arriving during the pause is captured on the first `rdy`=1 cycle. The pipeline guarantees the RAM holds output while `rdy`=0.

## Timing
- Reset values: `if_done`=0, `mem_done`=0, `if_rdata`=0, `mem_rdata`=0, `busy`=0, `ram_a`=0, `ram_dout`=0, `ram_wr`=0, state=IDLE, `cnt`=0.
- Cycle 0: request seen in IDLE. Cycle 1: first byte address or write on RAM.
- Read latency to done: n+2 cycles after accept (word: 6, half: 4, byte: 3).
- Write latency to done: n+1 cycles after accept (word: 5, byte: 2).
- Next request may be accepted the cycle after DONE. Maximum throughput is one word fetch per 7 cycles.
- `busy` is registered: high from cycle 1 through the DONE cycle.

## Structure
- Size codes (`MemByte`, `MemHalf`, `MemWord`) and state encodings go in the shared defines.v, alongside the existing `RstEnable` and `True_v`.
- One sub-module, `mem_ctrl_ext`: combinational size mask plus sign/zero extension of the 32-bit assembled buffer. It is reused by MEM-stage forwarding checks.
- The FSM, counter and arbitration stay in `mem_ctrl`.

## Test plan
- Word fetch: `if_re`, `if_addr`=0x100, RAM bytes 13,00,00,00 → `ram_a` 0x100..0x103 in cycles 1–4; `if_done` in cycle 6 with `if_rdata`=0x00000013.
- Signed byte load: `mem_addr`=0x2001, byte 0x80, `mem_signed`=1 → `mem_rdata`=0xFFFFFF80. With `mem_signed`=0 → 0x00000080.
- Word store 0xDEADBEEF at 0x3FFE → `ram_wr`=1 for exactly 4 cycles, data EF,BE,AD,DE at 0x3FFE..0x4001; `mem_done` at cycle 5.
- Collision: `if_re` and `mem_re` both high in the same cycle → MEM served first; IF accepted the cycle after `mem_done`, with no lost request.
- Wrap: half load at 0xFFFFFFFF → addresses 0xFFFFFFFF then 0x00000000.
- `rdy` dropped for 3 cycles mid word read, and separately `rst` pulsed mid write → the read result is unchanged with latency +3; after the reset `ram_wr`=0 and there is no `mem_done` pulse.
